path_recorder_multi: RTL and testbench
======================================

Name: path_recorder_multi

Overview:
- Parametrised next-generation path recorder for the self-navigating car.
- Captures the motor-command stream as {code, duration} segments into a DEPTH-entry buffer.
- Duration is quantised in prescaled ticks. Supports CH motor channels and a replay mode that re-drives the recorded path.
- Sits between the track-following controller (motor_in) and the motor drivers / UART reporter (motor_out, rd port).

Parameters:
CH, 2, number of motor command bits per entry
DUR_W, 8, width of per-segment duration (ticks)
DEPTH, 16, number of segment entries
TICK_DIV, 7644, clk cycles per duration tick (>=2)
AW, $clog2(DEPTH), derived pointer width (not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins record (mode=0) or replay (mode=1)
mode  in  1  0=record, 1=replay; sampled only with start
stop_req  in  1  ends record (flushing the open segment) or aborts replay
motor_in  in  CH  live motor command to record
motor_out  out  CH  replayed motor command; 0 outside PLAY
busy  out  1  high in REC or PLAY
done  out  1  high in DONE
full  out  1  buffer reached DEPTH entries during the last record
sat  out  1  sticky: some segment duration saturated
count  out  AW+1  number of valid entries
rd_addr  in  AW  random read address (UART dump)
rd_data  out  CH+DUR_W  entry at rd_addr, {code,dur}; registered, 1-cycle latency

Behaviour:
- Reset values: state IDLE, motor_out=0, busy=0, done=0, full=0, sat=0, count=0, rd_data=0, pointers/prescaler/dur=0. Memory contents are not cleared (hidden by count=0). Reset mid-operation aborts immediately with these values.
- States: IDLE, REC, PLAY, DONE. start is honoured in IDLE and DONE only; ignored while busy.
- start & mode=0:
  - go REC.
  - count<=0, full<=0, sat<=0.
  - prev<=motor_in, dur<=0, prescaler<=0.
- start & mode=1 & count>0: go PLAY at entry 0. With count==0: ignored, state unchanged.
- Prescaler counts 0..TICK_DIV-1 in REC and PLAY; tick = (prescaler==TICK_DIV-1), then wraps to 0.
- REC, each cycle, priority order:
  - (a) motor_in!=prev: write {prev,dur} at mem[count], count+1, prev<=motor_in, dur<=0, prescaler<=0. A tick in the same cycle is discarded.
  - (b) else on tick: dur<=dur+1, saturating at 2^DUR_W-1; an attempted increment at max sets sat.
  - After a write making count==DEPTH: full<=1, go DONE; later motor changes are ignored.
- stop_req in REC:
  - Write the open segment {prev,dur} (or the change-write if (a) fires the same cycle; exactly one write).
  - Then go DONE. Sets full if count reaches DEPTH.
- PLAY:
  - Load entry i: motor_out<=code, rem<=dur, prescaler<=0.
  - Each tick rem decrements. When rem==0, advance to i+1 on the next cycle.
  - A dur==0 entry is held exactly 1 cycle; a dur=d entry is held d*TICK_DIV cycles.
  - After entry count-1 completes: motor_out<=0, go DONE.
  - stop_req: motor_out<=0, go DONE next cycle.
- DONE: done=1, busy=0; count and buffer retained for rd port and repeat replay.
- rd port is always readable. Addresses >=count return stale data; no error flag.

Test Plan:
1. TICK_DIV=4: start mode=0 with motor_in=01, change to 10 sampled 13 cycles later -> mem[0]={01,3}, count=1 next cycle.
2. DEPTH=4: toggle motor_in every 2 cycles -> after 4th change count=4, full=1, done=1; 5th change leaves count=4.
3. DUR_W=3, TICK_DIV=4: hold 01 for 41 cycles, then change -> entry dur=7, sat=1.
4. Preload via record {01,3},{10,0},{11,2}; start mode=1 -> motor_out 01 for 12 cycles, 10 for 1, 11 for 8, then 00, done=1.
5. stop_req in REC after 2 entries with dur=5 accumulated -> entry2={prev,5}, count=3, DONE. stop_req coincident with a change -> only one write.
6. rst asserted mid-PLAY -> next cycle motor_out=00, count=0, busy=0. Subsequent start mode=1 is ignored.

Source files
------------

// File: rtl/path_recorder_multi_if.sv
// Bus between the track controller / UART reporter and the path recorder.
// The recorder owns the slave side; the controller or bench drives the master side.
interface path_recorder_multi_if #(
  parameter int unsigned CH    = 2,
  parameter int unsigned DUR_W = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                start;
  logic                mode;
  logic                stop_req;
  logic [CH-1:0]       motor_in;
  logic [CH-1:0]       motor_out;
  logic                busy;
  logic                done;
  logic                full;
  logic                sat;
  logic [AW:0]         count;
  logic [AW-1:0]       rd_addr;
  logic [CH+DUR_W-1:0] rd_data;

  modport master (
    output start, mode, stop_req, motor_in, rd_addr,
    input  motor_out, busy, done, full, sat, count, rd_data
  );

  modport slave (
    input  start, mode, stop_req, motor_in, rd_addr,
    output motor_out, busy, done, full, sat, count, rd_data
  );
endinterface

// File: rtl/path_recorder_multi.sv
// Records the motor-command stream as {code, duration} segments and replays it.
// Durations are counted in prescaled ticks of TICK_DIV clock cycles.
module path_recorder_multi #(
  parameter int unsigned CH       = 2,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 7644
) (
  input logic                 clk,
  input logic                 rst,
  path_recorder_multi_if.slave bus
);
  localparam int unsigned    AW        = $clog2(DEPTH);
  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam int unsigned    EW        = CH + DUR_W;
  localparam logic [DUR_W-1:0] DurMax  = '1;
  localparam logic [PW-1:0]  PreLast   = PW'(TICK_DIV - 1);
  localparam logic [AW:0]    CountFull = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRec, StPlay, StDone} state_e;

  state_e           state_q;
  logic [EW-1:0]    mem [DEPTH];
  logic [CH-1:0]    prev_q, motor_out_q;
  logic [DUR_W-1:0] dur_q, rem_q;
  logic [PW-1:0]    pre_q;
  logic [AW:0]      count_q;
  logic [AW-1:0]    idx_q;
  logic             busy_q, done_q, full_q, sat_q;
  logic [EW-1:0]    rd_data_q;

  logic          tick, rec_write, seg_end, last_entry;
  logic [AW:0]   count_inc;
  logic [AW-1:0] idx_next;
  logic [EW-1:0] first_entry, next_entry;

  assign tick        = (pre_q == PreLast);
  assign rec_write   = (state_q == StRec) && ((bus.motor_in != prev_q) || bus.stop_req);
  assign count_inc   = count_q + 1'b1;
  assign idx_next    = idx_q + 1'b1;
  assign last_entry  = (((AW + 1)'(idx_q)) + 1'b1) == count_q;
  assign first_entry = mem[AW'(0)];
  assign next_entry  = mem[idx_next];
  // Ending on the last tick (not one cycle later) gives exactly d*TICK_DIV cycles per entry.
  assign seg_end     = (rem_q == '0) || (tick && (rem_q == DUR_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst && rec_write) begin
      mem[count_q[AW-1:0]] <= {prev_q, dur_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      motor_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      sat_q       <= 1'b0;
      count_q     <= '0;
      rd_data_q   <= '0;
      prev_q      <= '0;
      dur_q       <= '0;
      rem_q       <= '0;
      pre_q       <= '0;
      idx_q       <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
      case (state_q)
        StIdle, StDone: begin
          if (bus.start && !bus.mode) begin
            state_q <= StRec;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            sat_q   <= 1'b0;
            prev_q  <= bus.motor_in;
            dur_q   <= '0;
            pre_q   <= '0;
          end else if (bus.start && (count_q != '0)) begin
            state_q     <= StPlay;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            idx_q       <= '0;
            motor_out_q <= first_entry[EW-1:DUR_W];
            rem_q       <= first_entry[DUR_W-1:0];
            pre_q       <= '0;
          end
        end
        StRec: begin
          if (rec_write) begin
            // A change and a stop in the same cycle share this single write.
            count_q <= count_inc;
            prev_q  <= bus.motor_in;
            dur_q   <= '0;
            pre_q   <= '0;
            if (count_inc == CountFull) full_q <= 1'b1;
            if (bus.stop_req || (count_inc == CountFull)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
              if (dur_q == DurMax) sat_q <= 1'b1;
              else                 dur_q <= dur_q + 1'b1;
            end
          end
        end
        StPlay: begin
          if (bus.stop_req || (seg_end && last_entry)) begin
            motor_out_q <= '0;
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (seg_end) begin
            idx_q       <= idx_next;
            motor_out_q <= next_entry[EW-1:DUR_W];
            rem_q       <= next_entry[DUR_W-1:0];
            pre_q       <= '0;
          end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) rem_q <= rem_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.motor_out = motor_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.full      = full_q;
  assign bus.sat       = sat_q;
  assign bus.count     = count_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_path_recorder_multi.sv
// Directed bench for path_recorder_multi: recorded entries and replayed commands are
// predicted into scoreboard queues and popped when read back / observed.
module tb_path_recorder_multi;
  localparam int unsigned CH       = 2;
  localparam int unsigned DUR_W    = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned EW       = CH + DUR_W;
  localparam int unsigned DMAX     = (1 << DUR_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_recorder_multi_if #(.CH(CH), .DUR_W(DUR_W), .DEPTH(DEPTH)) bus ();

  path_recorder_multi #(
    .CH(CH), .DUR_W(DUR_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int held  = 0;
  logic [CH-1:0] cur;
  logic [EW-1:0] exp_q [$];
  logic [CH-1:0] play_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DUR_W-1:0] dur_of(input int unsigned edges);
    int unsigned t;
    t = (edges - 1) / TICK_DIV;
    return DUR_W'((t > DMAX) ? DMAX : t);
  endfunction

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
    held++;
  endtask

  task automatic start_rec(input logic [CH-1:0] code);
    bus.motor_in = code;
    bus.mode     = 1'b0;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    held      = 0;
    cur       = code;
  endtask

  task automatic change(input logic [CH-1:0] code, input bit expect_write);
    bus.motor_in = code;
    if (expect_write) exp_q.push_back({cur, dur_of(held + 1)});
    step();
    held = 0;
    cur  = code;
  endtask

  task automatic stop_rec();
    bus.stop_req = 1'b1;
    exp_q.push_back({cur, dur_of(held + 1)});
    step();
    bus.stop_req = 1'b0;
  endtask

  task automatic dump();
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      bus.rd_addr = AW'(i);
      step();
      check($sformatf("rd[%0d]", i), bus.rd_data, exp_q.pop_front());
      i++;
    end
  endtask

  task automatic start_play();
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.stop_req = 1'b0;
    bus.motor_in = '0;
    bus.rd_addr  = '0;
    cur          = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.count, 0);
    check("rst_motor", bus.motor_out, 0);
    check("rst_full", bus.full, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_rd", bus.rd_data, 0);

    // Segment length quantised in ticks.
    start_rec(2'b01);
    repeat (12) step();
    change(2'b10, 1'b1);
    check("t1_count", bus.count, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_motor_rec", bus.motor_out, 0);
    stop_rec();
    check("t1_done", bus.done, 1);
    check("t1_count2", bus.count, 2);
    dump();

    // Buffer fills after DEPTH changes; later changes ignored.
    start_rec(2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      change((k % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
    end
    check("t2_count", bus.count, 4);
    check("t2_full", bus.full, 1);
    check("t2_done", bus.done, 1);
    check("t2_busy", bus.busy, 0);
    step();
    change(2'b01, 1'b0);
    check("t2_count_hold", bus.count, 4);
    dump();

    // Duration saturation and sticky sat.
    start_rec(2'b01);
    check("t3_full_clr", bus.full, 0);
    repeat (30) step();
    check("t3_sat_early", bus.sat, 0);
    repeat (10) step();
    change(2'b10, 1'b1);
    check("t3_sat", bus.sat, 1);
    stop_rec();
    check("t3_sat_sticky", bus.sat, 1);
    dump();

    // Record three entries then replay them.
    start_rec(2'b01);
    check("t4_sat_clr", bus.sat, 0);
    repeat (12) step();
    change(2'b10, 1'b1);
    change(2'b11, 1'b1);
    repeat (9) step();
    stop_rec();
    check("t4_count", bus.count, 3);
    dump();
    repeat (12) play_q.push_back(2'b01);
    play_q.push_back(2'b10);
    repeat (8) play_q.push_back(2'b11);
    start_play();
    check("t4_busy", bus.busy, 1);
    while (play_q.size() > 0) begin
      check("t4_play", bus.motor_out, play_q.pop_front());
      step();
    end
    check("t4_motor_end", bus.motor_out, 0);
    check("t4_done", bus.done, 1);
    check("t4_busy_end", bus.busy, 0);

    // stop_req flushes the open segment; coincident change writes once.
    start_rec(2'b00);
    repeat (2) step();
    change(2'b01, 1'b1);
    repeat (4) step();
    change(2'b10, 1'b1);
    repeat (20) step();
    stop_rec();
    check("t5_count", bus.count, 3);
    check("t5_done", bus.done, 1);
    dump();
    start_rec(2'b01);
    repeat (8) step();
    bus.motor_in = 2'b10;
    bus.stop_req = 1'b1;
    exp_q.push_back({cur, dur_of(held + 1)});
    step();
    bus.stop_req = 1'b0;
    check("t5_one_write", bus.count, 1);
    check("t5_done2", bus.done, 1);
    dump();

    // Reset mid-replay, then replay with an empty buffer is ignored.
    start_play();
    repeat (3) step();
    check("t6_busy", bus.busy, 1);
    check("t6_motor", bus.motor_out, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_motor_rst", bus.motor_out, 0);
    check("t6_count_rst", bus.count, 0);
    check("t6_busy_rst", bus.busy, 0);
    check("t6_done_rst", bus.done, 0);
    start_play();
    check("t6_ignored_busy", bus.busy, 0);
    check("t6_ignored_motor", bus.motor_out, 0);
    step();
    check("t6_ignored_done", bus.done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
